// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one combinational-read data memory between the
// pipeline MEM stage (port 0) and a secondary master (port 1).
module dmem_arbiter #(
  parameter int AW = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        We0,
  input  logic        We1,
  input  logic [31:0] Addr0,
  input  logic [31:0] Addr1,
  input  logic [31:0] Wdata0,
  input  logic [31:0] Wdata1,
  output logic        Ack0,
  output logic        Ack1,
  output logic        Err0,
  output logic        Err1,
  output logic [31:0] Rdata,
  output logic        DataMemWE,
  output logic [31:0] DataMemAddr,
  output logic [31:0] DataMemIn,
  input  logic [31:0] DataMemOut
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        lat_we_q, lat_we_d;
  logic        lat_err_q, lat_err_d;
  logic [31:0] lat_addr_q, lat_addr_d;
  logic [31:0] lat_wdata_q, lat_wdata_d;
  logic [31:0] rdata_q, rdata_d;

  logic        any_req;
  logic        gnt_port;
  logic        sel_we;
  logic [31:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_err;

  // On a tie the port that did not win last time is granted.
  assign any_req   = Req0 | Req1;
  assign gnt_port  = (Req0 & Req1) ? ~last_q : Req1;
  assign sel_we    = gnt_port ? We1 : We0;
  assign sel_addr  = gnt_port ? Addr1 : Addr0;
  assign sel_wdata = gnt_port ? Wdata1 : Wdata0;
  assign sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr[31:AW] != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    owner_d     = owner_q;
    last_d      = last_q;
    lat_we_d    = lat_we_q;
    lat_err_d   = lat_err_q;
    lat_addr_d  = lat_addr_q;
    lat_wdata_d = lat_wdata_q;
    rdata_d     = rdata_q;
    if (state_q == IDLE && any_req) begin
      owner_d     = gnt_port;
      last_d      = gnt_port;
      lat_we_d    = sel_we;
      lat_err_d   = sel_err;
      lat_addr_d  = sel_addr;
      lat_wdata_d = sel_wdata;
    end
    if (state_q == ACCESS)
      rdata_d = (lat_we_q | lat_err_q) ? 32'h0 : DataMemOut;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= 1'b0;
      last_q      <= 1'b1;
      lat_we_q    <= 1'b0;
      lat_err_q   <= 1'b0;
      lat_addr_q  <= '0;
      lat_wdata_q <= '0;
      rdata_q     <= '0;
    end else begin
      owner_q     <= owner_d;
      last_q      <= last_d;
      lat_we_q    <= lat_we_d;
      lat_err_q   <= lat_err_d;
      lat_addr_q  <= lat_addr_d;
      lat_wdata_q <= lat_wdata_d;
      rdata_q     <= rdata_d;
    end
  end

  // Decoded from registered state only, so async reset kills WE/Ack at once.
  always_comb begin
    DataMemWE = 1'b0;
    Ack0      = 1'b0;
    Ack1      = 1'b0;
    Err0      = 1'b0;
    Err1      = 1'b0;
    case (state_q)
      ACCESS: DataMemWE = lat_we_q & ~lat_err_q;
      RESP: begin
        Ack0 = ~owner_q;
        Ack1 = owner_q;
        Err0 = ~owner_q & lat_err_q;
        Err1 = owner_q & lat_err_q;
      end
      default: ;
    endcase
  end

  assign DataMemAddr = lat_addr_q;
  assign DataMemIn   = lat_wdata_q;
  assign Rdata       = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected
// responses, a monitor pops and compares on every Ack.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Req0 = 1'b0, Req1 = 1'b0, We0 = 1'b0, We1 = 1'b0;
  logic [31:0] Addr0 = '0, Addr1 = '0, Wdata0 = '0, Wdata1 = '0;
  logic        Ack0, Ack1, Err0, Err1, DataMemWE;
  logic [31:0] Rdata, DataMemAddr, DataMemIn, DataMemOut;

  logic [31:0] mem [0:1023];

  typedef struct {
    logic        port;
    logic        err;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int we_cnt = 0;
  logic [31:0] last_we_addr = '0;
  logic [31:0] last_we_data = '0;

  dmem_arbiter #(.AW(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .Req0(Req0), .Req1(Req1), .We0(We0), .We1(We1),
    .Addr0(Addr0), .Addr1(Addr1), .Wdata0(Wdata0), .Wdata1(Wdata1),
    .Ack0(Ack0), .Ack1(Ack1), .Err0(Err0), .Err1(Err1), .Rdata(Rdata),
    .DataMemWE(DataMemWE), .DataMemAddr(DataMemAddr), .DataMemIn(DataMemIn),
    .DataMemOut(DataMemOut)
  );

  always #5 clk = ~clk;

  assign DataMemOut = mem[DataMemAddr[11:2]];

  // Memory model: preloaded pattern 0x10000000 + 0x11*index, writes on rising edge.
  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 + 32'h11 * i;
    forever begin
      @(posedge clk);
      if (DataMemWE) mem[DataMemAddr[11:2]] = DataMemIn;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  task automatic push(input logic port, input logic err, input logic [31:0] rd);
    exp_t e;
    e.port = port; e.err = err; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every Ack against the scoreboard head.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (DataMemWE) begin
        we_cnt++;
        last_we_addr = DataMemAddr;
        last_we_data = DataMemIn;
      end
      if (Ack0 || Ack1) begin
        check("ack_overlap", 32'(Ack0 & Ack1), 32'h0);
        if (exp_q.size() == 0) begin
          check("unexpected_ack", 32'(exp_q.size()), 32'h1);
        end else begin
          e = exp_q.pop_front();
          check("ack_port", 32'(Ack1), 32'(e.port));
          check("ack_err", 32'(Ack1 ? Err1 : Err0), 32'(e.err));
          check("other_err", 32'(Ack1 ? Err0 : Err1), 32'h0);
          check("ack_rdata", Rdata, e.rdata);
        end
      end
    end
  end

  // Drive one request; drop (or let the caller re-raise) Req on the Ack cycle.
  task automatic req(input logic port, input logic we, input logic [31:0] addr,
                     input logic [31:0] wd, input int exp_lat);
    int lat;
    lat = 0;
    if (port) begin Req1 = 1'b1; We1 = we; Addr1 = addr; Wdata1 = wd; end
    else      begin Req0 = 1'b1; We0 = we; Addr0 = addr; Wdata0 = wd; end
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (port ? Ack1 : Ack0) begin lat = i; break; end
    end
    if (lat == 0) check("ack_timeout", 32'h0, 32'h1);
    else if (exp_lat != 0) check("ack_latency", 32'(lat), 32'(exp_lat));
    if (port) Req1 = 1'b0; else Req0 = 1'b0;
  endtask

  task automatic gap();
    repeat (2) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"}, 32'(DataMemWE), 32'h0);
    check({tag, "_addr"}, DataMemAddr, 32'h0);
    check({tag, "_din"}, DataMemIn, 32'h0);
    check({tag, "_rdata"}, Rdata, 32'h0);
    check({tag, "_ack"}, 32'({Ack1, Ack0}), 32'h0);
    check({tag, "_err"}, 32'({Err1, Err0}), 32'h0);
  endtask

  initial begin
    int w0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    gap();

    // Write then read-back through the other port.
    w0 = we_cnt;
    push(1'b0, 1'b0, 32'h0);
    req(1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 2);
    check("wr_we_cycles", 32'(we_cnt - w0), 32'h1);
    check("wr_we_addr", last_we_addr, 32'h10);
    check("wr_we_data", last_we_data, 32'hDEAD_BEEF);
    gap();
    push(1'b1, 1'b0, 32'hDEAD_BEEF);
    req(1'b1, 1'b0, 32'h10, 32'h0, 2);
    gap();

    // Continuous contention: strict alternation, port 0 first (port 1 won last).
    for (int i = 0; i < 3; i++) begin
      push(1'b0, 1'b0, 32'h1000_0000);
      push(1'b1, 1'b0, 32'h1000_0011);
    end
    fork
      for (int i = 0; i < 3; i++) req(1'b0, 1'b0, 32'h0, 32'h0, 0);
      for (int j = 0; j < 3; j++) req(1'b1, 1'b0, 32'h4, 32'h0, 0);
    join
    gap();

    // Rejected accesses: misaligned and out of range never write.
    w0 = we_cnt;
    push(1'b1, 1'b1, 32'h0);
    req(1'b1, 1'b1, 32'h6, 32'hFFFF_FFFF, 2);
    gap();
    push(1'b1, 1'b1, 32'h0);
    req(1'b1, 1'b1, 32'h1000, 32'hFFFF_FFFF, 2);
    gap();
    check("err_no_we", 32'(we_cnt - w0), 32'h0);
    push(1'b1, 1'b0, 32'h1000_0011);
    req(1'b1, 1'b0, 32'h4, 32'h0, 2);
    gap();
    push(1'b0, 1'b0, 32'h1000_0000);
    req(1'b0, 1'b0, 32'h0, 32'h0, 2);
    gap();

    // Req0 rising during port 1's ACCESS waits for the next IDLE.
    push(1'b1, 1'b0, 32'h1000_0022);
    push(1'b0, 1'b0, 32'h1000_0033);
    fork
      req(1'b1, 1'b0, 32'h8, 32'h0, 2);
      begin @(negedge clk); req(1'b0, 1'b0, 32'hC, 32'h0, 4); end
    join
    gap();

    // Reset in the middle of a write ACCESS.
    Req0 = 1'b1; We0 = 1'b1; Addr0 = 32'h20; Wdata0 = 32'h1234_5678;
    @(posedge clk); #1;
    check("mid_we_high", 32'(DataMemWE), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    Req0 = 1'b0; We0 = 1'b0;
    @(negedge clk); @(posedge clk); @(negedge clk);
    rst_n = 1'b1;
    gap();
    push(1'b1, 1'b0, 32'h1000_0088);
    req(1'b1, 1'b0, 32'h20, 32'h0, 2);
    gap();

    // Last word of the backed range.
    push(1'b0, 1'b0, 32'h1000_43EF);
    req(1'b0, 1'b0, 32'hFFC, 32'h0, 2);
    gap();
    push(1'b0, 1'b0, 32'h0);
    req(1'b0, 1'b1, 32'hFFC, 32'hCAFE_F00D, 2);
    gap();
    push(1'b0, 1'b0, 32'hCAFE_F00D);
    req(1'b0, 1'b0, 32'hFFC, 32'h0, 2);
    gap();

    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
